// File: rtl/mem_port_master_if.sv
// Datapath request/response channels and memory pins for mem_port_master.
// The master modport is the initiator's view. The slave modport is the environment's view.
interface mem_port_master_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespData;
  logic        RespErr;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWriteEnable;
  logic        MemRead;
  logic [31:0] MemData;

  modport master (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, RespReady, MemData,
    output ReqReady, RespValid, RespData, RespErr, MemAddress, MemWriteData,
           MemWriteEnable, MemRead
  );

  modport slave (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, RespReady, MemData,
    input  ReqReady, RespValid, RespData, RespErr, MemAddress, MemWriteData,
           MemWriteEnable, MemRead
  );
endinterface

// File: rtl/mem_port_master.sv
// Load/store initiator for a word-wide memory. Sub-word stores use read-modify-write.
// The block allows one outstanding request. Responses carry extended load data and an error flag.
module mem_port_master #(
  parameter int MEM_DEPTH    = 513,
  parameter bit WORD_INDEXED = 1'b1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  mem_port_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  localparam logic [1:0]  SZ_BYTE = 2'd0;
  localparam logic [1:0]  SZ_HALF = 2'd1;
  localparam logic [1:0]  SZ_WORD = 2'd2;
  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  state_e      state_q;
  logic        req_ready_q;
  logic        resp_valid_q, resp_err_q;
  logic [31:0] resp_data_q;
  logic        mem_read_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        write_q, signed_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q;

  logic        err_d;
  logic [31:0] mem_addr_d;
  logic [4:0]  lane_shift;
  logic [31:0] shifted, lane_mask, load_d, merge_d;

  // Request decode: error classification and the memory address format.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    err_d = 1'b0;
    case (bus.ReqSize)
      SZ_HALF: err_d = bus.ReqAddr[0];
      SZ_WORD: err_d = (bus.ReqAddr[1:0] != 2'b00);
      SZ_BYTE: err_d = 1'b0;
      default: err_d = 1'b1;
    endcase
    if ({2'b00, bus.ReqAddr[31:2]} >= DEPTH_W) err_d = 1'b1;
    mem_addr_d = WORD_INDEXED ? {2'b00, bus.ReqAddr[31:2]} : {bus.ReqAddr[31:2], 2'b00};
  end

  // Lane extraction for loads and lane merging for sub-word stores. Lanes are little-endian.
  always_comb begin
    lane_shift = {off_q, 3'b000};
    shifted    = bus.MemData >> lane_shift;
    load_d     = bus.MemData;
    lane_mask  = 32'hFFFF_FFFF;
    case (size_q)
      SZ_BYTE: begin
        load_d    = {{24{signed_q & shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << lane_shift;
      end
      SZ_HALF: begin
        load_d    = {{16{signed_q & shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << lane_shift;
      end
      default: ;
    endcase
    merge_d = (bus.MemData & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= SZ_BYTE;
      off_q        <= 2'b00;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.ReqValid && req_ready_q) begin
          req_ready_q <= 1'b0;
          write_q     <= bus.ReqWrite;
          signed_q    <= bus.ReqSigned;
          size_q      <= bus.ReqSize;
          off_q       <= bus.ReqAddr[1:0];
          wdata_q     <= bus.ReqWData;
          if (err_d) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_data_q  <= '0;
            state_q      <= RESP;
          end else if (!bus.ReqWrite || bus.ReqSize != SZ_WORD) begin
            mem_read_q <= 1'b1;
            mem_addr_q <= mem_addr_d;
            state_q    <= RD;
          end else begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= bus.ReqWData;
            state_q     <= WR;
          end
        end
        RD: begin
          mem_read_q <= 1'b0;
          if (write_q) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merge_d;
            state_q     <= WR;
          end else begin
            mem_addr_q   <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_data_q  <= load_d;
            state_q      <= RESP;
          end
        end
        WR: begin
          mem_we_q     <= 1'b0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_data_q  <= '0;
          state_q      <= RESP;
        end
        RESP: if (bus.RespReady) begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_data_q  <= '0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with Reset_n guarantees that no strobe or ready is seen while reset is held.
  assign bus.ReqReady       = req_ready_q & Reset_n;
  assign bus.MemRead        = mem_read_q & Reset_n;
  assign bus.MemWriteEnable = mem_we_q & Reset_n;
  assign bus.MemAddress     = mem_addr_q;
  assign bus.MemWriteData   = mem_wdata_q;
  assign bus.RespValid      = resp_valid_q;
  assign bus.RespData       = resp_data_q;
  assign bus.RespErr        = resp_err_q;

endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- CPU-side initiator for the unified word-wide instruction/data memory.
- Accepts load/store requests from the datapath over a valid/ready handshake and drives the memory's address, write-data, write-enable and read-enable pins.
- Word accesses map straight to memory cycles; byte and halfword stores use a read-modify-write sequence.
- Returns load data (zero- or sign-extended) and an error flag over a valid/ready response channel.

Parameters:
- MEM_DEPTH, 513, number of 32-bit words in the memory; word indices >= MEM_DEPTH are out of range.
- WORD_INDEXED, 1: MemAddress = ReqAddr[31:2]. 0: MemAddress = ReqAddr with bits [1:0] forced to 0.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request.
- ReqWrite  in  1  1=store, 0=load.
- ReqSize  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- ReqSigned  in  1  loads: sign-extend sub-word data.
- ReqAddr  in  32  byte address.
- ReqWData  in  32  store data, right-aligned.
- RespValid  out  1  response present.
- RespReady  in  1  consumer takes response.
- RespData  out  32  load result; 0 for stores and errors.
- RespErr  out  1  misaligned, illegal size, or out of range.
- MemAddress  out  32  to memory Address.
- MemWriteData  out  32  to memory WriteData.
- MemWriteEnable  out  1  to memory writeEnable.
- MemRead  out  1  to memory MemRead.
- MemData  in  32  from memory; combinational read of MemAddress.

Behaviour:
- Reset:
  - Reset_n low at a rising edge forces state IDLE.
  - All outputs read 0 in the cycle after reset, including ReqReady, which rises the first cycle Reset_n is high.
  - MemWriteEnable and MemRead are gated by Reset_n, so no memory write occurs in any cycle where Reset_n is low.
  - Reset mid-operation aborts with no write and drops any pending response.
- State IDLE:
  - ReqReady=1.
  - On ReqValid&&ReqReady, the block latches the request, computes the word index, and checks errors.
  - Errors are: size 3; half with addr[0]=1; word with addr[1:0]!=0; word index >= MEM_DEPTH.
  - Next state is RESP with error, RD for a load or a sub-word store, and WR for a word store.
- State RD:
  - MemRead=1 and MemAddress=latched index.
  - MemData is captured into the word buffer at the clock edge.
  - Load: extract lane, extend, then go to RESP.
  - Sub-word store: merge ReqWData into the addressed lane(s), then go to WR.
- Lanes: little-endian. Byte k occupies [8k+7:8k]. A halfword at addr[1]=h occupies [16h+15:16h].
- State WR:
  - MemWriteEnable=1, MemAddress=index, MemWriteData=full word or merged word; held exactly one cycle.
  - Next state is RESP.
- State RESP:
  - RespValid=1; RespData and RespErr are held stable until RespValid&&RespReady, then the block goes to IDLE.
  - ReqReady=0 in every state except IDLE, so there is one outstanding request maximum.
- Memory pins: outside RD/WR, MemRead=0, MemWriteEnable=0, MemAddress=0, MemWriteData=0.
- Latency from the acceptance edge T:
  - Error: RespValid from T+1.
  - Word load or word store: RespValid from T+2.
  - Sub-word store: RespValid from T+3.
  - Sub-word load: RespValid from T+2.
- Back-to-back: with RespReady tied high, a new request is accepted in the cycle after RESP. Throughput is one word op per 3 cycles.
- ReqValid while not ready is ignored. The requester holds the request until it sees the handshake.
- Sign extension applies only to loads with ReqSigned=1 and size byte/half. Word loads are never altered.

Test Plan:
- Reset: hold Reset_n=0 for 2 cycles with ReqValid=1, store, addr 0 -> MemWriteEnable stays 0 throughout; all outputs 0; ReqReady=1 one cycle after release.
- Word store then load:
  - Store 0xDEADBEEF to addr 0x18 (WORD_INDEXED=1) -> one cycle with MemWriteEnable=1 and MemAddress=6; response at T+2 with RespErr=0.
  - Loading 0x18 afterwards -> RespData=0xDEADBEEF.
- Byte read-modify-write: memory word 6 holds 0x11223344; byte store of 0xAA to 0x1A -> MemRead cycle, then write of 0x11AA3344; response at T+3.
- Signed and unsigned loads from word 6 = 0x11AA3344:
  - Byte signed @0x1A -> 0xFFFFFFAA.
  - Byte unsigned @0x1A -> 0x000000AA.
  - Half signed @0x1A -> 0x000011AA.
- Errors -> RespErr=1, RespData=0, no MemRead or MemWriteEnable pulse, RespValid at T+1:
  - Word @0x1B.
  - Half @0x19.
  - Size 3.
  - Word @ 513*4 (MEM_DEPTH=513).
- Backpressure: hold RespReady=0 for 5 cycles during a load response -> RespValid and RespData stable; ReqReady=0 and a second ReqValid is not accepted until the response handshake completes.
